// File: rtl/digit_scan_decoder.sv
// Time-multiplexed digit driver: per-digit value store, prescaled one-hot scan, per-digit blanking.
// Optional `DIGIT_SCAN_ACTIVE_LOW_EN makes anode active-low; all outputs are registered.
module digit_scan_decoder #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 4,
  parameter int PRESCALE = 1000,
  localparam int IDX_W   = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [DIGITS-1:0] anode,
  output logic [DATA_W-1:0] digit_data,
  output logic [IDX_W-1:0]  scan_idx,
  output logic              frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
`ifdef DIGIT_SCAN_ACTIVE_LOW_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{~ACT}};

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tc;
  logic              wrap;
  logic [DIGITS-1:0] onehot;
  logic [DATA_W-1:0] store [DIGITS];

  always_comb begin
    tc      = en && (cnt == CNT_LAST);
    wrap    = tc && (scan_idx == IDX_LAST);
    cnt_nxt = cnt;
    if (en) cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
    idx_nxt = scan_idx;
    if (tc) idx_nxt = wrap ? '0 : scan_idx + IDX_W'(1);
    onehot          = '0;
    onehot[idx_nxt] = 1'b1;
  end

  // Outputs are computed from the next index so anode, data and index stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
      digit_data <= '0;
      anode      <= ANODE_OFF;
      for (int i = 0; i < DIGITS; i++) store[i] <= '0;
    end else begin
      cnt        <= cnt_nxt;
      scan_idx   <= idx_nxt;
      frame_done <= wrap;
      digit_data <= store[idx_nxt];
      anode      <= (en && !blank_mask[idx_nxt]) ? (ACT ? onehot : ~onehot) : ANODE_OFF;
      if (load && (int'(load_idx) < DIGITS)) store[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Bench for digit_scan_decoder (DIGITS=4, DATA_W=4, PRESCALE=3) with a per-cycle scoreboard.
// Honours `DIGIT_SCAN_ACTIVE_LOW_EN for the anode polarity.
module tb_digit_scan_decoder;
  localparam int D = 4;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_idx = '0;
  logic [3:0] load_data = '0;
  logic [3:0] blank_mask = '0;
  logic [3:0] anode;
  logic [3:0] digit_data;
  logic [1:0] scan_idx;
  logic       frame_done;

  digit_scan_decoder #(.DIGITS(D), .DATA_W(4), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_idx(load_idx),
    .load_data(load_data), .blank_mask(blank_mask), .anode(anode),
    .digit_data(digit_data), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

`ifdef DIGIT_SCAN_ACTIVE_LOW_EN
  localparam logic [3:0] OFF = 4'b1111;
  function automatic logic [3:0] act(input logic [3:0] oh); return ~oh; endfunction
`else
  localparam logic [3:0] OFF = 4'b0000;
  function automatic logic [3:0] act(input logic [3:0] oh); return oh; endfunction
`endif

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] data;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_store [D];

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    for (int i = 0; i < D; i++) m_store[i] = '0;
  endtask

  // Predict the next edge from current inputs, advance one clock, compare.
  task automatic step();
    exp_t e;
    exp_t g;
    bit   tc;
    int   nidx;
    if (!rst_n) begin
      model_reset();
      e = '{anode: OFF, data: 4'h0, idx: 2'd0, fd: 1'b0};
    end else begin
      tc   = en && (m_cnt == P - 1);
      nidx = tc ? (m_idx + 1) % D : m_idx;
      e.anode = (en && !blank_mask[nidx]) ? act(4'b0001 << nidx) : OFF;
      e.data  = m_store[nidx];
      e.idx   = 2'(nidx);
      e.fd    = tc && (m_idx == D - 1);
      if (en) m_cnt = tc ? 0 : m_cnt + 1;
      m_idx = nidx;
      if (load && int'(load_idx) < D) m_store[load_idx] = load_data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    checks++;
    if ({anode, digit_data, scan_idx, frame_done} !== g) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got anode=%b data=%h idx=%0d fd=%b, want anode=%b data=%h idx=%0d fd=%b",
               $time, anode, digit_data, scan_idx, frame_done, g.anode, g.data, g.idx, g.fd);
    end
  endtask

  // Advance until the model reaches the given index/count; bounded.
  task automatic run_to(input int idx, input int cnt);
    int n = 0;
    while (!(m_idx == idx && m_cnt == cnt) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL run_to timeout: idx=%0d cnt=%0d not reached", idx, cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    #1;
    checks++;
    if ({anode, digit_data, scan_idx, frame_done} !== {OFF, 4'h0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got anode=%b data=%h idx=%0d fd=%b, want anode=%b 0 0 0",
               anode, digit_data, scan_idx, frame_done, OFF);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  // First slot after release: idx 0 for a full period, then the scan order.
  task automatic test_scan_order();
    int fd_cnt = 0;
    int run = 0;
    logic [3:0] prev;
    step(); step();
    checks++;
    if (scan_idx !== 2'd0 || anode !== act(4'b0001)) begin
      errors++;
      $display("FAIL first_slot: got idx=%0d anode=%b, want idx=0 anode=%b", scan_idx, anode, act(4'b0001));
    end
    step();
    checks++;
    if (scan_idx !== 2'd1) begin
      errors++;
      $display("FAIL first_advance: got idx=%0d, want 1", scan_idx);
    end
    prev = anode;
    run  = 1;
    for (int i = 0; i < 2 * D * P; i++) begin
      step();
      if (frame_done) fd_cnt++;
      if (anode === prev) run++;
      else begin
        checks++;
        if (run != P || anode !== act({prev[2:0], prev[3]} ^ ({4{OFF[0]}} & 4'b0000) ) && OFF == 4'b0000) begin
          errors++;
          $display("FAIL slot_len: got run=%0d next=%b after %b, want run=%0d", run, anode, prev, P);
        end
        prev = anode;
        run  = 1;
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, want 2", fd_cnt);
    end
  endtask

  task automatic test_store();
    logic [3:0] vals [D];
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'hA; vals[3] = 4'hF;
    for (int i = 0; i < D; i++) begin
      load = 1'b1; load_idx = 2'(i); load_data = vals[i];
      step();
    end
    load = 1'b0;
    step();
    for (int i = 0; i < D * P; i++) begin
      step();
      checks++;
      if (anode !== act(4'b0001 << scan_idx) || digit_data !== vals[scan_idx]) begin
        errors++;
        $display("FAIL readback: got anode=%b data=%h at idx=%0d, want anode=%b data=%h",
                 anode, digit_data, scan_idx, act(4'b0001 << scan_idx), vals[scan_idx]);
      end
    end
  endtask

  task automatic test_blank();
    blank_mask = 4'b0100;
    for (int i = 0; i < D * P; i++) begin
      step();
      if (m_idx == 2) begin
        checks++;
        if (anode !== OFF || digit_data !== 4'hA) begin
          errors++;
          $display("FAIL blank_slot: got anode=%b data=%h, want anode=%b data=a", anode, digit_data, OFF);
        end
      end
    end
    blank_mask = 4'b0000;
    step();
  endtask

  task automatic test_pause();
    run_to(1, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (anode !== OFF || scan_idx !== 2'd1) begin
        errors++;
        $display("FAIL pause: got anode=%b idx=%0d, want anode=%b idx=1", anode, scan_idx, OFF);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (scan_idx !== 2'd1 || anode !== act(4'b0010)) begin
      errors++;
      $display("FAIL resume_hold: got idx=%0d anode=%b, want idx=1 anode=%b", scan_idx, anode, act(4'b0010));
    end
    step();
    checks++;
    if (scan_idx !== 2'd2) begin
      errors++;
      $display("FAIL resume_advance: got idx=%0d, want 2", scan_idx);
    end
  endtask

  task automatic test_same_idx_write();
    run_to(2, 0);
    load = 1'b1; load_idx = 2'd2; load_data = 4'h7;
    step();
    load = 1'b0;
    step();
    checks++;
    if (scan_idx !== 2'd2 || digit_data !== 4'h7) begin
      errors++;
      $display("FAIL same_idx_write: got idx=%0d data=%h, want idx=2 data=7", scan_idx, digit_data);
    end
  endtask

  task automatic test_async_reset();
    run_to(3, 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({anode, digit_data, scan_idx, frame_done} !== {OFF, 4'h0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got anode=%b data=%h idx=%0d fd=%b, want anode=%b 0 0 0",
               anode, digit_data, scan_idx, frame_done, OFF);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < P; i++) begin
      step();
      checks++;
      if (scan_idx !== ((i == P - 1) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL restart_slot edge %0d: got idx=%0d, want %0d", i, scan_idx, (i == P - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_order();
    test_store();
    test_blank();
    test_pause();
    test_same_idx_write();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
